// File: rtl/if_prefetch_queue_if.sv
// Fetch-queue bundle: redirect/halt control, imem request/response and the decode-side handshake.
interface if_prefetch_queue_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              halt;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [INS_W-1:0]  imem_rdata;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INS_W-1:0]  out_instr;
    logic              out_ready;
    logic [OCC_W-1:0]  occupancy;
    logic              halted;

    modport master (
        input  redirect_valid, redirect_pc, halt, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_instr, occupancy, halted
    );

    modport slave (
        output redirect_valid, redirect_pc, halt, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, occupancy, halted
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Fetch PC owner and in-order {pc, instr} queue feeding decode; request-to-out_valid latency 2 cycles.
// Fetches are credit-limited (occupancy + inflight < DEPTH) so decode backpressure never overflows the queue.
module if_prefetch_queue #(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    if_prefetch_queue_if.master bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = OCC_W + 1;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HALTING = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    logic [1:0]       state;
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  req_pc;
    logic             inflight;
    entry_t           fifo [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic [CW-1:0]    fill;
    logic             issue;
    logic             push;
    logic             pop;
    logic             has_head;

    // Credit uses registered occupancy only; a same-cycle pop does not free a slot.
    assign fill     = CW'(occ) + CW'(inflight);
    assign issue    = !reset && (state == ST_RUN) && !bus.halt && !bus.redirect_valid
                      && (fill < CW'(DEPTH));
    assign push     = inflight && !bus.redirect_valid;
    assign has_head = (occ != '0);
    assign pop      = bus.out_valid && bus.out_ready;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = has_head && !bus.redirect_valid;
    assign bus.out_pc    = has_head ? fifo[rd_ptr].pc    : '0;
    assign bus.out_instr = has_head ? fifo[rd_ptr].instr : '0;
    assign bus.occupancy = occ;
    assign bus.halted    = (state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{pc: req_pc, instr: bus.imem_rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc <= fetch_pc;
            end

            if (bus.redirect_valid) begin
                fetch_pc <= {bus.redirect_pc[PC_W-1:2], 2'b00};
            end else if (issue) begin
                fetch_pc <= fetch_pc + PC_W'(4);
            end

            // A redirect drops the queue and the response landing this cycle.
            if (bus.redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                occ <= occ + OCC_W'(push) - OCC_W'(pop);
            end

            case (state)
                ST_RUN:     if (bus.halt) state <= inflight ? ST_HALTING : ST_HALTED;
                ST_HALTING: if (!inflight) state <= ST_HALTED;
                default:    state <= state;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (occ == OCC_W'(DEPTH))));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: reset vectors, a table of cycle vectors, directed corner sequences, and random traffic against a queue model.
module tb_if_prefetch_queue;
    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;
    localparam int WORDS = 1 << (PC_W - 2);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_prefetch_queue_if #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) bus ();

    if_prefetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous instruction memory: one-cycle read latency.
    logic [INS_W-1:0] mem [WORDS];
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr[PC_W-1:2]];
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: a queue of fetched PCs plus one outstanding request.
    logic [PC_W-1:0] mq[$];
    logic [PC_W-1:0] m_fpc = '0;
    logic [PC_W-1:0] m_pend_pc = '0;
    bit m_pend = 0;
    bit m_halt = 0;
    bit model_on = 0;
    logic [PC_W-1:0] obs[$];

    task automatic eval_model(output bit req, output bit vld, output logic [PC_W-1:0] pc,
                              output logic [INS_W-1:0] ins, output int occ);
        occ = mq.size();
        vld = (occ > 0) && !bus.redirect_valid;
        pc  = (occ > 0) ? mq[0] : '0;
        ins = (occ > 0) ? mem[pc[PC_W-1:2]] : '0;
        req = !reset && !m_halt && !bus.halt && !bus.redirect_valid && (occ + int'(m_pend) < DEPTH);
    endtask

    task automatic model_edge();
        bit req, vld;
        logic [PC_W-1:0] pc;
        logic [INS_W-1:0] ins;
        int occ;
        eval_model(req, vld, pc, ins, occ);
        if (reset) begin
            mq.delete();
            m_fpc = '0; m_pend = 0; m_halt = 0;
            return;
        end
        if (bus.redirect_valid) begin
            mq.delete();
            m_fpc = {bus.redirect_pc[PC_W-1:2], 2'b00};
        end else begin
            if (vld && bus.out_ready) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_pc);
        end
        if (bus.halt) m_halt = 1;
        m_pend = req;
        if (req) begin
            m_pend_pc = m_fpc;
            m_fpc = m_fpc + 4;
        end
    endtask

    task automatic sample();
        bit req, vld;
        logic [PC_W-1:0] pc;
        logic [INS_W-1:0] ins;
        int occ;
        @(negedge clk);
        if (model_on) begin
            eval_model(req, vld, pc, ins, occ);
            chk("m_imem_req",  bus.imem_req,  req);
            chk("m_imem_addr", bus.imem_addr, m_fpc);
            chk("m_out_valid", bus.out_valid, vld);
            chk("m_out_pc",    bus.out_pc,    pc);
            chk("m_out_instr", bus.out_instr, ins);
            chk("m_occupancy", bus.occupancy, 64'(occ));
        end
        if (bus.out_valid && bus.out_ready) obs.push_back(bus.out_pc);
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    typedef struct {
        bit              ready;
        bit              req;
        logic [PC_W-1:0] addr;
        bit              vld;
        logic [PC_W-1:0] pc;
        int              occ;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input bit r, input bit q, input int a, input bit v, input int p, input int o);
        vec_t t;
        t.ready = r; t.req = q; t.addr = PC_W'(a); t.vld = v; t.pc = PC_W'(p); t.occ = o;
        vecs.push_back(t);
    endtask

    initial begin
        bit found;
        bit any_req;
        int hcyc;

        for (int i = 0; i < WORDS; i++) mem[i] = ($urandom() << PC_W) | 32'(i * 4);

        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.halt = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_imem_req",  bus.imem_req,  0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_pc",    bus.out_pc,    0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_halted",    bus.halted,    0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_on = 1;

        // Cycle vectors from reset release: streaming, 10-cycle stall, release.
        add_vec(1, 1,  0, 0,  0, 0);
        add_vec(1, 1,  4, 0,  0, 0);
        add_vec(1, 1,  8, 1,  0, 1);
        add_vec(1, 1, 12, 1,  4, 1);
        add_vec(0, 1, 16, 1,  8, 1);
        add_vec(0, 1, 20, 1,  8, 2);
        add_vec(0, 0, 24, 1,  8, 3);
        for (int i = 0; i < 7; i++) add_vec(0, 0, 24, 1, 8, 4);
        add_vec(1, 0, 24, 1,  8, 4);
        add_vec(1, 1, 24, 1, 12, 3);
        add_vec(1, 1, 28, 1, 16, 2);
        add_vec(1, 1, 32, 1, 20, 2);
        add_vec(1, 1, 36, 1, 24, 2);
        obs.delete();
        foreach (vecs[i]) begin
            bus.out_ready = vecs[i].ready;
            sample();
            chk($sformatf("tv%0d_req", i),   bus.imem_req,  vecs[i].req);
            chk($sformatf("tv%0d_addr", i),  bus.imem_addr, vecs[i].addr);
            chk($sformatf("tv%0d_valid", i), bus.out_valid, vecs[i].vld);
            if (vecs[i].vld) begin
                chk($sformatf("tv%0d_pc", i),    bus.out_pc, vecs[i].pc);
                chk($sformatf("tv%0d_instr", i), bus.out_instr[PC_W-1:0], vecs[i].pc);
            end
            chk($sformatf("tv%0d_occ", i), bus.occupancy, 64'(vecs[i].occ));
            advance();
        end
        chk("drain_count", 64'(obs.size()), 7);
        for (int i = 0; i < obs.size(); i++) chk("drain_order", obs[i], 64'(i * 4));

        // Redirect with 3 queued and 1 in flight.
        bus.out_ready = 1'b0;
        cyc();
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h043;
        sample();
        chk("rd_occ_before", bus.occupancy, 3);
        chk("rd_valid_t0",   bus.out_valid, 0);
        advance();
        bus.redirect_valid = 1'b0;
        obs.delete();
        sample();
        chk("rd_valid_t1", bus.out_valid, 0);
        chk("rd_addr_t1",  bus.imem_addr, 9'h040);
        chk("rd_req_t1",   bus.imem_req,  1);
        advance();
        cyc();
        sample();
        chk("rd_valid_t3", bus.out_valid, 1);
        chk("rd_pc_t3",    bus.out_pc,    9'h040);
        advance();
        repeat (3) cyc();
        chk("rd_count", 64'(obs.size()), 4);
        for (int i = 0; i < obs.size(); i++) chk("rd_no_stale", obs[i], 64'(9'h040 + i * 4));

        // Redirect near the top of the address space: PC wraps.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h1FE;
        cyc();
        bus.redirect_valid = 1'b0;
        obs.delete();
        repeat (6) cyc();
        chk("wrap_count", 64'(obs.size() >= 3), 1);
        if (obs.size() >= 3) begin
            chk("wrap_pc0", obs[0], 9'h1FC);
            chk("wrap_pc1", obs[1], 9'h000);
            chk("wrap_pc2", obs[2], 9'h004);
        end

        // Random traffic against the model.
        for (int blk = 0; blk < 15; blk++) begin
            int rp;
            rp = $urandom_range(2, 10);
            for (int i = 0; i < 100; i++) begin
                bus.out_ready = ($urandom_range(0, 9) < rp);
                bus.redirect_valid = ($urandom_range(0, 19) == 0);
                bus.redirect_pc = PC_W'($urandom());
                cyc();
            end
        end
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;

        // Halt right after the fetch of 0x010.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h000;
        cyc();
        bus.redirect_valid = 1'b0;
        obs.delete();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            sample();
            if (bus.imem_req && bus.imem_addr == 9'h010) found = 1;
            advance();
        end
        chk("halt_fetch_seen", found, 1);
        bus.halt = 1'b1;
        sample();
        chk("halt_req_in_pulse", bus.imem_req, 0);
        advance();
        bus.halt = 1'b0;
        any_req = 0;
        hcyc = -1;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (bus.imem_req) any_req = 1;
            if (bus.halted && hcyc < 0) hcyc = i;
            advance();
        end
        chk("halt_no_req", any_req, 0);
        chk("halt_halted_soon", 64'(hcyc >= 0 && hcyc <= 1), 1);
        chk("halt_drain_count", 64'(obs.size()), 5);
        if (obs.size() == 5) chk("halt_drain_last", obs[4], 9'h010);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h080;
        cyc();
        bus.redirect_valid = 1'b0;
        sample();
        chk("halted_redir_req",  bus.imem_req,  0);
        chk("halted_redir_addr", bus.imem_addr, 9'h080);
        chk("halted_stays",      bus.halted,    1);
        advance();

        // Reset mid-operation with entries queued and a fetch outstanding.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.out_ready = 1'b0;
        repeat (4) cyc();
        sample();
        chk("pre_rst_occ", bus.occupancy, 3);
        reset = 1'b1;
        advance();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        obs.delete();
        sample();
        chk("post_rst_valid",  bus.out_valid, 0);
        chk("post_rst_occ",    bus.occupancy, 0);
        chk("post_rst_halted", bus.halted,    0);
        chk("post_rst_addr",   bus.imem_addr, 0);
        chk("post_rst_req",    bus.imem_req,  1);
        advance();
        repeat (5) cyc();
        chk("post_rst_count", 64'(obs.size() >= 2), 1);
        if (obs.size() >= 2) begin
            chk("post_rst_pc0", obs[0], 0);
            chk("post_rst_pc1", obs[1], 4);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
